// File: rtl/vx_bitscan_pkg.sv
// Shared types and width helpers for the set-bit iterator.
// Optional flush feature is enabled with the VX_BITSCAN_FLUSH_EN macro.
`default_nettype none

package vx_bitscan_pkg;

  typedef enum logic [0:0] {
    BS_IDLE = 1'b0,
    BS_SCAN = 1'b1
  } bs_state_e;

  function automatic int idx_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // One extra code point so a full mask never wraps the beat counter
  function automatic int seq_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vx_bitscan_iter_if.sv
// Mask-in / index-out handshake bundle for vx_bitscan_iter.
`default_nettype none

interface vx_bitscan_iter_if #(
  parameter int WIDTH = 32,
  parameter int IDXW  = vx_bitscan_pkg::idx_width(WIDTH),
  parameter int SEQW  = vx_bitscan_pkg::seq_width(WIDTH)
);

  logic             in_valid;
  logic [WIDTH-1:0] in_mask;
  logic             in_ready;
  logic             out_valid;
  logic [IDXW-1:0]  out_index;
  logic [SEQW-1:0]  out_seq;
  logic             out_last;
  logic             out_empty;
  logic             out_ready;
  logic             busy;

  modport master (
    output in_valid, in_mask, out_ready,
    input  in_ready, out_valid, out_index, out_seq, out_last, out_empty, busy
  );

  modport slave (
    input  in_valid, in_mask, out_ready,
    output in_ready, out_valid, out_index, out_seq, out_last, out_empty, busy
  );

endinterface

`default_nettype wire

// File: rtl/vx_bitscan_prio.sv
// Combinational find-first-set: index per MODE plus one-hot of the selected bit.
`default_nettype none

module vx_bitscan_prio #(
  parameter int WIDTH = 32,
  parameter int MODE  = 0,
  parameter int IDXW  = vx_bitscan_pkg::idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  output logic [IDXW-1:0]  index,
  output logic [WIDTH-1:0] onehot
);

  generate
    if (MODE == 0) begin : g_lsb_first
      // Scan downward so the lowest set bit is the final write
      always_comb begin
        index  = '0;
        onehot = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (mask[i]) begin
            index     = IDXW'(i);
            onehot    = '0;
            onehot[i] = 1'b1;
          end
        end
      end
    end else begin : g_msb_first
      // Highest set bit wins; index is its distance from the MSB
      always_comb begin
        index  = '0;
        onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
          if (mask[i]) begin
            index     = IDXW'(WIDTH - 1 - i);
            onehot    = '0;
            onehot[i] = 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/vx_bitscan_iter.sv
// Sequential set-bit iterator: one index beat per cycle, zero-bubble mask reload.
// Define VX_BITSCAN_FLUSH_EN to add the flush port.
`default_nettype none

module vx_bitscan_iter
  import vx_bitscan_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MODE  = 0
) (
  input  logic               clk,
  input  logic               reset_n,
`ifdef VX_BITSCAN_FLUSH_EN
  input  logic               flush,
`endif
  vx_bitscan_iter_if.slave   bus
);

  localparam int IDXW = idx_width(WIDTH);
  localparam int SEQW = seq_width(WIDTH);

  bs_state_e        state_r;
  bs_state_e        state_nxt;
  logic [WIDTH-1:0] mask_r;
  logic [SEQW-1:0]  seq_r;
  logic             empty_r;

  logic [IDXW-1:0]  sel_index;
  logic [WIDTH-1:0] sel_onehot;
  logic [WIDTH-1:0] mask_rest;
  logic             is_scan;
  logic             last_beat;
  logic             flush_req;
  logic             accept;
  logic             fire;
  logic             in_ready_w;

`ifdef VX_BITSCAN_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  vx_bitscan_prio #(
    .WIDTH (WIDTH),
    .MODE  (MODE),
    .IDXW  (IDXW)
  ) u_prio (
    .mask   (mask_r),
    .index  (sel_index),
    .onehot (sel_onehot)
  );

  assign is_scan    = (state_r == BS_SCAN);
  assign mask_rest  = mask_r & ~sel_onehot;
  assign last_beat  = empty_r || (mask_rest == '0);
  // out_ready reaches in_ready combinationally to allow back-to-back masks
  assign in_ready_w = !flush_req &&
                      (!is_scan || (bus.out_ready && last_beat));
  assign accept     = bus.in_valid && in_ready_w;
  assign fire       = is_scan && bus.out_ready && !flush_req;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= BS_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state_r;
    if (flush_req) begin
      state_nxt = BS_IDLE;
    end else begin
      case (state_r)
        BS_IDLE: begin
          if (accept) state_nxt = BS_SCAN;
        end
        BS_SCAN: begin
          if (fire && last_beat) state_nxt = accept ? BS_SCAN : BS_IDLE;
        end
        default: state_nxt = BS_IDLE;
      endcase
    end
  end

  // Scan datapath: accept reloads, fire retires the selected bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_r  <= '0;
      seq_r   <= '0;
      empty_r <= 1'b0;
    end else if (flush_req) begin
      mask_r  <= '0;
      seq_r   <= '0;
      empty_r <= 1'b0;
    end else if (accept) begin
      mask_r  <= bus.in_mask;
      seq_r   <= '0;
      empty_r <= (bus.in_mask == '0);
    end else if (fire) begin
      mask_r  <= mask_rest;
      seq_r   <= seq_r + 1'b1;
    end
  end

  // Output logic
  always_comb begin
    bus.in_ready  = in_ready_w;
    bus.busy      = is_scan;
    bus.out_valid = is_scan;
    bus.out_index = '0;
    bus.out_seq   = '0;
    bus.out_last  = 1'b0;
    bus.out_empty = 1'b0;
    if (is_scan) begin
      bus.out_index = sel_index;
      bus.out_seq   = seq_r;
      bus.out_last  = last_beat;
      bus.out_empty = empty_r;
    end
  end

endmodule

`default_nettype wire
